// File: rtl/z80_regfile_pkg.sv
// z80_regfile_pkg
// Shared definitions for the Z80 register file: register-name codes
// (reg_select), physical register indices, byte-lane encodings and small
// helpers for classifying names and merging/extracting byte lanes.
// Supported read-port count is MIN_READ..MAX_READ.
package z80_regfile_pkg;

    localparam int REG_SEL_W = 5;
    localparam int MIN_READ  = 1;
    localparam int MAX_READ  = 4;

    // Codes 17..31 are unused: writes to them are dropped, reads return 0.
    typedef enum logic [REG_SEL_W-1:0] {
        REG_A  = 5'd0,
        REG_F  = 5'd1,
        REG_B  = 5'd2,
        REG_C  = 5'd3,
        REG_D  = 5'd4,
        REG_E  = 5'd5,
        REG_H  = 5'd6,
        REG_L  = 5'd7,
        REG_AF = 5'd8,
        REG_BC = 5'd9,
        REG_DE = 5'd10,
        REG_HL = 5'd11,
        REG_IX = 5'd12,
        REG_IY = 5'd13,
        REG_SP = 5'd14,
        REG_I  = 5'd15,
        REG_R  = 5'd16
    } reg_select;

    // Physical storage. I and R live in the low byte of their entries.
    localparam int NUM_PHYS = 13;
    localparam int PHYS_W   = 4;
    localparam logic [PHYS_W-1:0] PH_AF0 = 4'd0;
    localparam logic [PHYS_W-1:0] PH_AF1 = 4'd1;
    localparam logic [PHYS_W-1:0] PH_BC0 = 4'd2;
    localparam logic [PHYS_W-1:0] PH_BC1 = 4'd3;
    localparam logic [PHYS_W-1:0] PH_DE0 = 4'd4;
    localparam logic [PHYS_W-1:0] PH_DE1 = 4'd5;
    localparam logic [PHYS_W-1:0] PH_HL0 = 4'd6;
    localparam logic [PHYS_W-1:0] PH_HL1 = 4'd7;
    localparam logic [PHYS_W-1:0] PH_IX  = 4'd8;
    localparam logic [PHYS_W-1:0] PH_IY  = 4'd9;
    localparam logic [PHYS_W-1:0] PH_SP  = 4'd10;
    localparam logic [PHYS_W-1:0] PH_I   = 4'd11;
    localparam logic [PHYS_W-1:0] PH_R   = 4'd12;

    // Byte lanes touched by a name: {high, low}.
    localparam logic [1:0] LANES_NONE = 2'b00;
    localparam logic [1:0] LANES_LO   = 2'b01;
    localparam logic [1:0] LANES_HI   = 2'b10;
    localparam logic [1:0] LANES_WORD = 2'b11;

    function automatic logic reg_is_8bit(input logic [REG_SEL_W-1:0] r);
        return r inside {REG_A, REG_F, REG_B, REG_C, REG_D, REG_E,
                         REG_H, REG_L, REG_I, REG_R};
    endfunction

    function automatic logic reg_is_16bit(input logic [REG_SEL_W-1:0] r);
        return r inside {REG_AF, REG_BC, REG_DE, REG_HL, REG_IX, REG_IY, REG_SP};
    endfunction

    // Replace the selected lanes of old with data; 8-bit writes take data[7:0].
    function automatic logic [15:0] merge_lanes(input logic [15:0] old,
                                                input logic [1:0]  lanes,
                                                input logic [15:0] data);
        case (lanes)
            LANES_WORD: return data;
            LANES_HI:   return {data[7:0], old[7:0]};
            LANES_LO:   return {old[15:8], data[7:0]};
            default:    return old;
        endcase
    endfunction

    // Extract a read value; 8-bit names are zero-extended, no lanes reads 0.
    function automatic logic [15:0] read_lanes(input logic [15:0] val,
                                               input logic [1:0]  lanes);
        case (lanes)
            LANES_WORD: return val;
            LANES_HI:   return {8'h00, val[15:8]};
            LANES_LO:   return {8'h00, val[7:0]};
            default:    return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/z80_reg_resolve.sv
// z80_reg_resolve
// Combinational name resolution: maps a register name to a physical
// register index and the byte lanes it occupies, using the current
// bank/swap mapping bits.
// Ports:
//   name      - register name code (reg_select encoding)
//   af_bank   - active AF bank
//   main_bank - active BC/DE/HL bank
//   swap      - per-main-bank DE/HL swap bits
//   phys      - resolved physical index (PH_AF0 when name is unknown)
//   lanes     - byte lanes touched (LANES_NONE when name is unknown)
module z80_reg_resolve
    import z80_regfile_pkg::*;
(
    input  logic [REG_SEL_W-1:0] name,
    input  logic                 af_bank,
    input  logic                 main_bank,
    input  logic [1:0]           swap,
    output logic [PHYS_W-1:0]    phys,
    output logic [1:0]           lanes
);

    logic [PHYS_W-1:0] af_p, bc_p, de_p, hl_p;
    logic              hi;

    // NOTE: every signal assigned in always_comb gets a default on entry so
    // no path through the case can leave it holding a value (latch).
    always_comb begin
        af_p = af_bank ? PH_AF1 : PH_AF0;
        bc_p = main_bank ? PH_BC1 : PH_BC0;
        // EX DE,HL is a rename, so DE and HL trade physical pairs.
        if (swap[main_bank]) begin
            de_p = main_bank ? PH_HL1 : PH_HL0;
            hl_p = main_bank ? PH_DE1 : PH_DE0;
        end else begin
            de_p = main_bank ? PH_DE1 : PH_DE0;
            hl_p = main_bank ? PH_HL1 : PH_HL0;
        end

        phys = PH_AF0;
        hi   = 1'b0;
        case (name)
            REG_A:  begin phys = af_p; hi = 1'b1; end
            REG_F:  phys = af_p;
            REG_AF: phys = af_p;
            REG_B:  begin phys = bc_p; hi = 1'b1; end
            REG_C:  phys = bc_p;
            REG_BC: phys = bc_p;
            REG_D:  begin phys = de_p; hi = 1'b1; end
            REG_E:  phys = de_p;
            REG_DE: phys = de_p;
            REG_H:  begin phys = hl_p; hi = 1'b1; end
            REG_L:  phys = hl_p;
            REG_HL: phys = hl_p;
            REG_IX: phys = PH_IX;
            REG_IY: phys = PH_IY;
            REG_SP: phys = PH_SP;
            REG_I:  phys = PH_I;
            REG_R:  phys = PH_R;
            default: phys = PH_AF0;
        endcase

        if (reg_is_16bit(name))     lanes = LANES_WORD;
        else if (reg_is_8bit(name)) lanes = hi ? LANES_HI : LANES_LO;
        else                        lanes = LANES_NONE;
    end

endmodule

// File: rtl/z80_regfile.sv
// z80_regfile
// Z80 register file with physical main/alternate banks. Exchanges only
// flip mapping bits, so EX AF,AF' / EXX / EX DE,HL complete in one cycle.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   write_en, dest, in    - register write (8-bit targets use in[7:0])
//   src, out              - NUM_READ packed read selects / read data
//   write_flags_en, f_in  - write current F (loses to a write of AF or F)
//   f_out, i_out, r_out   - current F, I, R from stored state
//   ex_af, exx, ex_de_hl  - exchange commands
//   r_inc                 - increment R[6:0], R[7] held
// Parameters: NUM_READ (MIN_READ..MAX_READ), BYPASS (1 = forward same-cycle writes).
module z80_regfile
    import z80_regfile_pkg::*;
#(
    parameter int NUM_READ = 2,
    parameter int BYPASS   = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          write_en,
    input  reg_select                     dest,
    input  logic [15:0]                   in,
    input  logic [NUM_READ*REG_SEL_W-1:0] src,
    output logic [NUM_READ*16-1:0]        out,
    input  logic [7:0]                    f_in,
    input  logic                          write_flags_en,
    output logic [7:0]                    f_out,
    input  logic                          ex_af,
    input  logic                          exx,
    input  logic                          ex_de_hl,
    input  logic                          r_inc,
    output logic [7:0]                    i_out,
    output logic [7:0]                    r_out
);

    logic [15:0]       regs [NUM_PHYS];
    logic              af_bank;
    logic              main_bank;
    logic [1:0]        swap;

    logic [PHYS_W-1:0] wr_phys;
    logic [1:0]        wr_lanes;
    logic [15:0]       wr_merged;
    logic [PHYS_W-1:0] af_cur;
    logic              flag_blocked;

    z80_reg_resolve u_wr_resolve (
        .name      (dest),
        .af_bank   (af_bank),
        .main_bank (main_bank),
        .swap      (swap),
        .phys      (wr_phys),
        .lanes     (wr_lanes)
    );

    assign wr_merged    = merge_lanes(regs[wr_phys], wr_lanes, in);
    assign af_cur       = af_bank ? PH_AF1 : PH_AF0;
    // A register write that covers F (AF or F) owns the flag byte this cycle.
    assign flag_blocked = write_en && (wr_phys == af_cur) && wr_lanes[0];

    // NOTE: state uses non-blocking assignments; the flag write is placed
    // after the register write so it overrides only the F byte when both
    // hit the same AF entry (e.g. write A plus flags).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the array is small and must read 0 after reset, so it is
            // cleared in the reset branch like any other flop.
            for (int p = 0; p < NUM_PHYS; p++) regs[p] <= '0;
            af_bank   <= 1'b0;
            main_bank <= 1'b0;
            swap      <= 2'b00;
        end else begin
            if (write_en && wr_lanes != LANES_NONE)
                regs[wr_phys] <= wr_merged;
            if (write_flags_en && !flag_blocked)
                regs[af_cur][7:0] <= f_in;
            if (r_inc && !(write_en && dest == REG_R))
                regs[PH_R][6:0] <= regs[PH_R][6:0] + 7'd1;
            // All mapping updates read the pre-exchange bits.
            if (ex_af)    af_bank         <= ~af_bank;
            if (ex_de_hl) swap[main_bank] <= ~swap[main_bank];
            if (exx)      main_bank       <= ~main_bank;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
        logic [PHYS_W-1:0] rd_phys;
        logic [1:0]        rd_lanes;
        logic [15:0]       rd_word;
        logic              hit;

        z80_reg_resolve u_rd_resolve (
            .name      (src[k*REG_SEL_W +: REG_SEL_W]),
            .af_bank   (af_bank),
            .main_bank (main_bank),
            .swap      (swap),
            .phys      (rd_phys),
            .lanes     (rd_lanes)
        );

        // Forwarding the merged word gives new bytes where written and
        // stored bytes elsewhere, e.g. write H, read HL -> {in[7:0], L}.
        assign hit     = (BYPASS != 0) && write_en && (wr_lanes != LANES_NONE)
                         && (wr_phys == rd_phys);
        assign rd_word = hit ? wr_merged : regs[rd_phys];
        assign out[k*16 +: 16] = read_lanes(rd_word, rd_lanes);
    end

    assign f_out = regs[af_cur][7:0];
    assign i_out = regs[PH_I][7:0];
    assign r_out = regs[PH_R][7:0];

`ifdef Z80_FORMAL
`define Z80_REG_PROBE(NAME, IDX) logic [15:0] NAME; assign NAME = regs[IDX];
    `Z80_REG_PROBE(probe_af0, PH_AF0)
    `Z80_REG_PROBE(probe_af1, PH_AF1)
    `Z80_REG_PROBE(probe_bc0, PH_BC0)
    `Z80_REG_PROBE(probe_bc1, PH_BC1)
    `Z80_REG_PROBE(probe_de0, PH_DE0)
    `Z80_REG_PROBE(probe_de1, PH_DE1)
    `Z80_REG_PROBE(probe_hl0, PH_HL0)
    `Z80_REG_PROBE(probe_hl1, PH_HL1)
    `Z80_REG_PROBE(probe_ix, PH_IX)
    `Z80_REG_PROBE(probe_iy, PH_IY)
    `Z80_REG_PROBE(probe_sp, PH_SP)
    `Z80_REG_PROBE(probe_i, PH_I)
    `Z80_REG_PROBE(probe_r, PH_R)
`endif

endmodule

// File: tb/tb_z80_regfile.sv
// tb_z80_regfile
// Drives two z80_regfile instances (NUM_READ=3, BYPASS=0 and BYPASS=1) with
// identical stimulus. Directed scenarios compare against hand-derived
// constants; the random phase compares against a name-level model that
// tracks the register set as the programmer sees it.
module tb_z80_regfile;
    import z80_regfile_pkg::*;

    localparam int NR = 3;

    typedef struct packed {
        logic [1:0][15:0] af, bc, de, hl;
        logic [15:0]      ix, iy, sp;
        logic [7:0]       i, r;
        logic             afb, mb;
        logic [1:0]       sw;
    } mstate_t;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    write_en, write_flags_en, ex_af, exx, ex_de_hl, r_inc;
    reg_select               dest;
    logic [15:0]             in_data;
    logic [NR*REG_SEL_W-1:0] src;
    logic [7:0]              f_in;
    logic [NR*16-1:0]        out_nb, out_bp;
    logic [7:0]              f_nb, f_bp, i_nb, i_bp, r_nb, r_bp;

    int      total = 0;
    int      bad   = 0;
    mstate_t model;

    always #5 clk = ~clk;

    z80_regfile #(.NUM_READ(NR), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .write_en(write_en), .dest(dest), .in(in_data),
        .src(src), .out(out_nb), .f_in(f_in), .write_flags_en(write_flags_en),
        .f_out(f_nb), .ex_af(ex_af), .exx(exx), .ex_de_hl(ex_de_hl),
        .r_inc(r_inc), .i_out(i_nb), .r_out(r_nb)
    );

    z80_regfile #(.NUM_READ(NR), .BYPASS(1)) dut_bp (
        .clk(clk), .reset(reset), .write_en(write_en), .dest(dest), .in(in_data),
        .src(src), .out(out_bp), .f_in(f_in), .write_flags_en(write_flags_en),
        .f_out(f_bp), .ex_af(ex_af), .exx(exx), .ex_de_hl(ex_de_hl),
        .r_inc(r_inc), .i_out(i_bp), .r_out(r_bp)
    );

    // ---------------- reference model (register names, not hardware) -----
    function automatic logic [15:0] m_read(mstate_t s, logic [4:0] name);
        logic [15:0] af, bc, de, hl;
        af = s.af[s.afb];
        bc = s.bc[s.mb];
        de = s.sw[s.mb] ? s.hl[s.mb] : s.de[s.mb];
        hl = s.sw[s.mb] ? s.de[s.mb] : s.hl[s.mb];
        case (name)
            REG_A:  return {8'h00, af[15:8]};
            REG_F:  return {8'h00, af[7:0]};
            REG_B:  return {8'h00, bc[15:8]};
            REG_C:  return {8'h00, bc[7:0]};
            REG_D:  return {8'h00, de[15:8]};
            REG_E:  return {8'h00, de[7:0]};
            REG_H:  return {8'h00, hl[15:8]};
            REG_L:  return {8'h00, hl[7:0]};
            REG_AF: return af;
            REG_BC: return bc;
            REG_DE: return de;
            REG_HL: return hl;
            REG_IX: return s.ix;
            REG_IY: return s.iy;
            REG_SP: return s.sp;
            REG_I:  return {8'h00, s.i};
            REG_R:  return {8'h00, s.r};
            default: return 16'h0000;
        endcase
    endfunction

    function automatic mstate_t m_write(mstate_t s, logic [4:0] name, logic [15:0] d);
        mstate_t n;
        logic    sw;
        n  = s;
        sw = s.sw[s.mb];
        case (name)
            REG_A:  n.af[s.afb][15:8] = d[7:0];
            REG_F:  n.af[s.afb][7:0]  = d[7:0];
            REG_AF: n.af[s.afb]       = d;
            REG_B:  n.bc[s.mb][15:8]  = d[7:0];
            REG_C:  n.bc[s.mb][7:0]   = d[7:0];
            REG_BC: n.bc[s.mb]        = d;
            REG_D:  if (sw) n.hl[s.mb][15:8] = d[7:0]; else n.de[s.mb][15:8] = d[7:0];
            REG_E:  if (sw) n.hl[s.mb][7:0]  = d[7:0]; else n.de[s.mb][7:0]  = d[7:0];
            REG_DE: if (sw) n.hl[s.mb]       = d;      else n.de[s.mb]       = d;
            REG_H:  if (sw) n.de[s.mb][15:8] = d[7:0]; else n.hl[s.mb][15:8] = d[7:0];
            REG_L:  if (sw) n.de[s.mb][7:0]  = d[7:0]; else n.hl[s.mb][7:0]  = d[7:0];
            REG_HL: if (sw) n.de[s.mb]       = d;      else n.hl[s.mb]       = d;
            REG_IX: n.ix = d;
            REG_IY: n.iy = d;
            REG_SP: n.sp = d;
            REG_I:  n.i  = d[7:0];
            REG_R:  n.r  = d[7:0];
            default: ;
        endcase
        return n;
    endfunction

    function automatic mstate_t m_step(mstate_t s, logic we, logic [4:0] d, logic [15:0] v,
                                       logic fwe, logic [7:0] fv, logic xaf, logic xx,
                                       logic xdh, logic ri);
        mstate_t n;
        n = s;
        if (we) n = m_write(n, d, v);
        if (fwe && !(we && (d == REG_AF || d == REG_F))) n.af[s.afb][7:0] = fv;
        if (ri && !(we && d == REG_R)) n.r = {n.r[7], n.r[6:0] + 7'd1};
        if (xaf) n.afb = ~s.afb;
        if (xdh) n.sw[s.mb] = ~s.sw[s.mb];
        if (xx)  n.mb = ~s.mb;
        return n;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        write_en = 1'b0; write_flags_en = 1'b0; ex_af = 1'b0; exx = 1'b0;
        ex_de_hl = 1'b0; r_inc = 1'b0; dest = REG_A; in_data = 16'h0000; f_in = 8'h00;
    endtask

    task automatic set_src(input logic [4:0] p0, input logic [4:0] p1, input logic [4:0] p2);
        src = {p2, p1, p0};
    endtask

    // Advance one clock; model follows the DUT at the rising edge.
    task automatic tick();
        @(posedge clk);
        if (reset) model = '0;
        else model = m_step(model, write_en, dest, in_data, write_flags_en, f_in,
                            ex_af, exx, ex_de_hl, r_inc);
        @(negedge clk);
        #1;
    endtask

    task automatic do_write(input reg_select d, input logic [15:0] v);
        idle(); write_en = 1'b1; dest = d; in_data = v;
        tick();
        idle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle(); set_src(REG_AF, REG_HL, 5'd31);
        reset = 1'b1; model = '0;
        #2;
        total++;
        if ({out_nb, out_bp, f_nb, f_bp, i_nb, i_bp, r_nb, r_bp} !== '0) begin
            bad++; $display("FAIL reset_state got=%h exp=0",
                            {out_nb, out_bp, f_nb, f_bp, i_nb, i_bp, r_nb, r_bp});
        end
        @(negedge clk); reset = 1'b0; #1;
        tick();
        total++;
        if ({out_nb, out_bp, f_nb, i_nb, r_nb} !== '0) begin
            bad++; $display("FAIL reset_release got=%h exp=0", {out_nb, out_bp, f_nb, i_nb, r_nb});
        end
    endtask

    task automatic test_bc();
        do_write(REG_BC, 16'h1234);
        set_src(REG_BC, REG_C, REG_B); #1;
        total++;
        if (out_nb !== {16'h0012, 16'h0034, 16'h1234}) begin
            bad++; $display("FAIL bc_read got=%h exp=%h", out_nb, {16'h0012, 16'h0034, 16'h1234});
        end
    endtask

    task automatic test_reset_mid();
        idle(); write_en = 1'b1; dest = REG_AF; in_data = 16'hFFFF;
        ex_af = 1'b1; exx = 1'b1; ex_de_hl = 1'b1; r_inc = 1'b1;
        write_flags_en = 1'b1; f_in = 8'hFF;
        #1; reset = 1'b1;
        tick();
        idle(); reset = 1'b0;
        tick();
        set_src(REG_AF, REG_BC, REG_R); #1;
        total++;
        if ({out_nb, out_bp, f_nb, i_nb, r_nb} !== '0) begin
            bad++; $display("FAIL reset_mid got=%h exp=0", {out_nb, out_bp, f_nb, i_nb, r_nb});
        end
    endtask

    task automatic test_ex_af();
        set_src(REG_AF, REG_F, REG_A);
        do_write(REG_AF, 16'hAA55);
        ex_af = 1'b1; tick(); idle();
        do_write(REG_AF, 16'h1111);
        total++;
        if (f_nb !== 8'h11) begin bad++; $display("FAIL ex_af_alt_f got=%h exp=11", f_nb); end
        write_flags_en = 1'b1; f_in = 8'h3C; tick(); idle();
        total++;
        if (out_nb[15:0] !== 16'h113C) begin
            bad++; $display("FAIL ex_af_alt_flags got=%h exp=113c", out_nb[15:0]);
        end
        ex_af = 1'b1; tick(); idle();
        total++;
        if (out_nb !== {16'h00AA, 16'h0055, 16'hAA55} || f_nb !== 8'h55) begin
            bad++; $display("FAIL ex_af_restore got=%h/%h exp=%h/55", out_nb, f_nb,
                            {16'h00AA, 16'h0055, 16'hAA55});
        end
    endtask

    task automatic test_ex_de_hl();
        set_src(REG_DE, REG_HL, REG_D);
        do_write(REG_DE, 16'h1111);
        do_write(REG_HL, 16'h2222);
        ex_de_hl = 1'b1; tick(); idle();
        total++;
        if (out_nb !== {16'h0022, 16'h1111, 16'h2222}) begin
            bad++; $display("FAIL ex_de_hl got=%h exp=%h", out_nb, {16'h0022, 16'h1111, 16'h2222});
        end
        exx = 1'b1; tick(); idle();
        total++;
        if (out_nb !== '0) begin bad++; $display("FAIL exx_alt got=%h exp=0", out_nb); end
        exx = 1'b1; tick(); idle();
        total++;
        if (out_nb !== {16'h0022, 16'h1111, 16'h2222}) begin
            bad++; $display("FAIL exx_back got=%h exp=%h", out_nb, {16'h0022, 16'h1111, 16'h2222});
        end
    endtask

    task automatic test_same_cycle();
        set_src(REG_DE, REG_HL, REG_BC);
        idle(); write_en = 1'b1; dest = REG_HL; in_data = 16'hBEEF; ex_de_hl = 1'b1;
        tick(); idle();
        total++;
        if (out_nb[31:0] !== {16'h2222, 16'hBEEF}) begin
            bad++; $display("FAIL write_with_swap got=%h exp=2222beef", out_nb[31:0]);
        end
        write_flags_en = 1'b1; f_in = 8'h5A; ex_af = 1'b1; tick(); idle();
        total++;
        if (f_nb !== 8'h3C) begin bad++; $display("FAIL flags_with_ex_af got=%h exp=3c", f_nb); end
        ex_af = 1'b1; tick(); idle();
        set_src(REG_AF, REG_HL, REG_BC); #1;
        total++;
        if (f_nb !== 8'h5A || out_nb[15:0] !== 16'hAA5A) begin
            bad++; $display("FAIL flags_old_bank got=%h/%h exp=5a/aa5a", f_nb, out_nb[15:0]);
        end
        write_en = 1'b1; dest = REG_BC; in_data = 16'h0BC0; exx = 1'b1; tick(); idle();
        total++;
        if (out_nb[47:32] !== 16'h0000) begin
            bad++; $display("FAIL write_with_exx got=%h exp=0000", out_nb[47:32]);
        end
        exx = 1'b1; tick(); idle();
        total++;
        if (out_nb[47:32] !== 16'h0BC0) begin
            bad++; $display("FAIL exx_write_old_bank got=%h exp=0bc0", out_nb[47:32]);
        end
    endtask

    task automatic test_r();
        set_src(REG_I, REG_R, REG_A);
        do_write(REG_R, 16'h127F);
        r_inc = 1'b1; tick(); idle();
        total++;
        if (r_nb !== 8'h00) begin bad++; $display("FAIL r_wrap_7f got=%h exp=00", r_nb); end
        do_write(REG_R, 16'h00FF);
        r_inc = 1'b1; tick(); idle();
        total++;
        if (r_nb !== 8'h80 || out_nb[31:16] !== 16'h0080) begin
            bad++; $display("FAIL r_wrap_ff got=%h/%h exp=80/0080", r_nb, out_nb[31:16]);
        end
        write_en = 1'b1; dest = REG_R; in_data = 16'h0005; r_inc = 1'b1; tick(); idle();
        total++;
        if (r_nb !== 8'h05) begin bad++; $display("FAIL r_write_wins got=%h exp=05", r_nb); end
        do_write(REG_I, 16'hEEC3);
        total++;
        if (i_nb !== 8'hC3 || out_nb[15:0] !== 16'h00C3) begin
            bad++; $display("FAIL i_write got=%h/%h exp=c3/00c3", i_nb, out_nb[15:0]);
        end
    endtask

    task automatic test_bypass();
        // A=0xAA, HL=0x2222 at this point.
        idle(); set_src(REG_HL, REG_H, REG_A);
        write_en = 1'b1; dest = REG_H; in_data = 16'h559A; #1;
        total++;
        if (out_bp !== {16'h00AA, 16'h009A, 16'h9A22}) begin
            bad++; $display("FAIL bypass_on got=%h exp=%h", out_bp, {16'h00AA, 16'h009A, 16'h9A22});
        end
        total++;
        if (out_nb !== {16'h00AA, 16'h0022, 16'h2222}) begin
            bad++; $display("FAIL bypass_off got=%h exp=%h", out_nb, {16'h00AA, 16'h0022, 16'h2222});
        end
        tick(); idle();
        total++;
        if (out_nb !== {16'h00AA, 16'h009A, 16'h9A22}) begin
            bad++; $display("FAIL bypass_after got=%h exp=%h", out_nb, {16'h00AA, 16'h009A, 16'h9A22});
        end
        set_src(REG_HL, 5'd17, 5'd31); #1;
        total++;
        if (out_bp !== {16'h0000, 16'h0000, 16'h9A22}) begin
            bad++; $display("FAIL unknown_code got=%h exp=%h", out_bp, {16'h0000, 16'h0000, 16'h9A22});
        end
    endtask

    task automatic test_random();
        mstate_t     bpm;
        logic [15:0] exp_nb, exp_bp;
        idle(); reset = 1'b1; #1;
        tick();
        reset = 1'b0;
        for (int n = 0; n < 400; n++) begin
            write_en       = ($urandom_range(0, 1) == 1);
            dest           = reg_select'(5'($urandom_range(0, 18)));
            in_data        = 16'($urandom);
            write_flags_en = ($urandom_range(0, 9) < 3);
            f_in           = 8'($urandom);
            ex_af          = ($urandom_range(0, 9) < 2);
            exx            = ($urandom_range(0, 9) < 2);
            ex_de_hl       = ($urandom_range(0, 9) < 2);
            r_inc          = ($urandom_range(0, 9) < 3);
            set_src(5'($urandom_range(0, 18)), 5'($urandom_range(0, 18)),
                    5'($urandom_range(0, 18)));
            #1;
            bpm = write_en ? m_write(model, dest, in_data) : model;
            for (int k = 0; k < NR; k++) begin
                logic [4:0] s;
                s      = src[k*REG_SEL_W +: REG_SEL_W];
                exp_nb = m_read(model, s);
                exp_bp = m_read(bpm, s);
                total++;
                if (out_nb[k*16 +: 16] !== exp_nb) begin
                    bad++; $display("FAIL rand_nb cyc=%0d port=%0d src=%0d got=%h exp=%h",
                                    n, k, s, out_nb[k*16 +: 16], exp_nb);
                end
                total++;
                if (out_bp[k*16 +: 16] !== exp_bp) begin
                    bad++; $display("FAIL rand_bp cyc=%0d port=%0d src=%0d got=%h exp=%h",
                                    n, k, s, out_bp[k*16 +: 16], exp_bp);
                end
            end
            total++;
            if ({f_nb, f_bp, i_nb, i_bp, r_nb, r_bp} !==
                {model.af[model.afb][7:0], model.af[model.afb][7:0], model.i, model.i,
                 model.r, model.r}) begin
                bad++; $display("FAIL rand_fir cyc=%0d got=%h exp=%h%h%h", n,
                                {f_nb, f_bp, i_nb, i_bp, r_nb, r_bp},
                                model.af[model.afb][7:0], model.i, model.r);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        src = '0;
        model = '0;
        test_reset();
        test_bc();
        test_reset_mid();
        test_ex_af();
        test_ex_de_hl();
        test_same_cycle();
        test_r();
        test_bypass();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
